memory_responder: RTL and testbench
===================================

// Module: memory_responder
// PURPOSE
// Memory-side responder for the load/store unit request interface. Services byte and
// halfword load/store requests against an internal byte-wide RAM. Halfwords take two
// byte beats. Completion is acknowledged with a one-cycle reset_memory_access pulse,
// which also clears the requester's access flags.
// PARAMETERS
// ADDR_WIDTH   8  RAM address bits; depth = 2**ADDR_WIDTH bytes; target_address[15:ADDR_WIDTH] ignored
// WAIT_STATES  0  extra idle cycles inserted before the first byte beat (0..15)
// PORTS
// clock                         in   1   system clock, all logic on posedge
// reset                         in   1   synchronous, active-high
// memory_access_load_byte       in   1   level request, held until acknowledged
// memory_access_load_halfword   in   1   level request, held until acknowledged
// memory_access_store_byte      in   1   level request, held until acknowledged
// memory_access_store_halfword  in   1   level request, held until acknowledged
// target_address                in   16  byte address of the access
// target_data                   in   16  store data: byte stores use [7:0]
// memory_data                   out  16  load result, held until the next load completes
// reset_memory_access           out  1   one-cycle completion pulse
// busy                          out  1   high in every state except IDLE
// conflict_error                out  1   sticky: more than one request flag seen at once
// BEHAVIOUR
// - Reset (sync): state=IDLE; memory_data=16'h0000; reset_memory_access=0; busy=0;
//   conflict_error=0; wait counter=0. RAM contents are not cleared by reset.
// - FSM states: IDLE, WAIT, LO, HI, ACK.
// - IDLE: if any flag is high, latch op, addr=target_address[ADDR_WIDTH-1:0] and
//   target_data; load counter=WAIT_STATES; go to WAIT if WAIT_STATES>0, else to LO.
// - Priority when several flags are high: store_halfword > store_byte > load_halfword
//   > load_byte. Execute only the winner and set conflict_error=1 until reset.
// - WAIT: decrement the counter each cycle; move to LO when it reaches 1.
// - LO: operate on byte addr. A store writes data[7:0]. A load captures the byte into
//   the low half of a result register. Byte ops then go to ACK; halfword ops go to HI.
// - HI: operate on byte (addr+1) mod 2**ADDR_WIDTH, so the address wraps at the top of
//   the RAM. A store writes data[15:8]. A load captures the high byte. Go to ACK.
//   Byte order is little-endian.
// - ACK: reset_memory_access=1 for exactly one cycle, then return to IDLE.
//   * Loads: memory_data is updated on entry to ACK. Byte loads give {8'h00, byte}.
//     Halfword loads give {hi, lo}.
//   * Stores leave memory_data unchanged.
// - Requester flags drop on the edge that samples the ACK pulse, so IDLE sees them low
//   and no request is ever serviced twice.
// - Request inputs are sampled only in IDLE. Changes while busy are ignored.
// - Latency (request first high in cycle 0): the ACK pulse is in cycle
//   2+WAIT_STATES for byte ops and cycle 3+WAIT_STATES for halfword ops.
//   Back-to-back requests are accepted in the cycle after ACK.
// - Reset mid-operation: abort to IDLE. A RAM write scheduled on the reset edge is
//   suppressed, and any byte already written stays written. No ACK pulse is produced.
// - Single-port RAM with synchronous write. The read path is combinational from the
//   RAM array into the capture register.
// TESTING
// 1. WAIT_STATES=0: store_halfword addr 0x0010 data 0xBEEF, then load_halfword 0x0010
//    -> memory_data=0xBEEF; ack pulses in cycle 3 of each request; busy high cycles 1..3.
// 2. store_byte addr 0x0011 data 0x0042, then load_halfword 0x0010 -> 0x42EF;
//    load_byte 0x0010 -> 0x00EF.
// 3. ADDR_WIDTH=8: store_halfword addr 0xA2FF data 0x1234 -> load_byte 0x0000 gives
//    0x0012 and load_byte 0x00FF gives 0x0034 (wrap, and upper address bits ignored).
// 4. WAIT_STATES=3: load_byte -> ack in cycle 5; load_halfword -> ack in cycle 6;
//    exactly one ack pulse per request.
// 5. load_byte and store_byte together, addr 0x0020 data 0x0077 -> store executes;
//    conflict_error=1 and stays 1; a later load_byte 0x0020 returns 0x0077.
// 6. Reset asserted in HI of store_halfword 0x0030 data 0xAB55 -> no ack pulse; outputs
//    return to reset values; load_byte 0x0030 gives 0x0055 and 0x0031 is unchanged.

Source files
------------

// File: rtl/memory_responder_if.sv
// Request/response bundle between a load/store requester and memory_responder.
// The requester holds its access flag until it samples the reset_memory_access pulse.
interface memory_responder_if;
  logic        memory_access_load_byte;
  logic        memory_access_load_halfword;
  logic        memory_access_store_byte;
  logic        memory_access_store_halfword;
  logic [15:0] target_address;
  logic [15:0] target_data;
  logic [15:0] memory_data;
  logic        reset_memory_access;
  logic        busy;
  logic        conflict_error;

  modport master (
    output memory_access_load_byte, memory_access_load_halfword,
           memory_access_store_byte, memory_access_store_halfword,
           target_address, target_data,
    input  memory_data, reset_memory_access, busy, conflict_error
  );

  modport slave (
    input  memory_access_load_byte, memory_access_load_halfword,
           memory_access_store_byte, memory_access_store_halfword,
           target_address, target_data,
    output memory_data, reset_memory_access, busy, conflict_error
  );
endinterface

// File: rtl/memory_responder.sv
// Byte-wide RAM responder: services byte/halfword loads and stores in one or two
// byte beats (little-endian) and acknowledges each with a one-cycle pulse.
module memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic               clock,
  input logic               reset,
  memory_responder_if.slave bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LO, ST_HI, ST_ACK} state_e;
  typedef enum logic [1:0] {OP_LB, OP_LH, OP_SB, OP_SH} op_e;

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_hi;
  logic [15:0]             wdata_q, wdata_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [7:0]              lo_q, lo_d;
  logic [15:0]             mdata_q, mdata_d;
  logic                    conflict_q, conflict_d;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [7:0]              wbyte;
  logic [3:0]              req;
  logic                    is_store;

  logic [7:0] mem [DEPTH];

  assign req = {bus.memory_access_store_halfword, bus.memory_access_store_byte,
                bus.memory_access_load_halfword,  bus.memory_access_load_byte};
  assign addr_hi  = addr_q + ADDR_WIDTH'(1);
  assign is_store = (op_q == OP_SB) || (op_q == OP_SH);

  if (ADDR_WIDTH < 16) begin : g_addr_unused
    logic addr_unused;
    assign addr_unused = ^bus.target_address[15:ADDR_WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    mdata_d    = mdata_q;
    conflict_d = conflict_q;
    we         = 1'b0;
    waddr      = addr_q;
    wbyte      = wdata_q[7:0];
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          if (req[3])      op_d = OP_SH;
          else if (req[2]) op_d = OP_SB;
          else if (req[1]) op_d = OP_LH;
          else             op_d = OP_LB;
          // More than one bit set: clearing the lowest set bit leaves something behind.
          if (|(req & (req - 4'd1))) conflict_d = 1'b1;
          addr_d  = bus.target_address[ADDR_WIDTH-1:0];
          wdata_d = bus.target_data;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_LO;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_LO;
      end
      ST_LO: begin
        if (is_store) begin
          we    = 1'b1;
          waddr = addr_q;
          wbyte = wdata_q[7:0];
        end else begin
          lo_d = mem[addr_q];
          if (op_q == OP_LB) mdata_d = {8'h00, mem[addr_q]};
        end
        state_d = ((op_q == OP_LB) || (op_q == OP_SB)) ? ST_ACK : ST_HI;
      end
      ST_HI: begin
        if (is_store) begin
          we    = 1'b1;
          waddr = addr_hi;
          wbyte = wdata_q[15:8];
        end else begin
          mdata_d = {mem[addr_hi], lo_q};
        end
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mdata_q    <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mdata_q    <= mdata_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    lo_q    <= lo_d;
  end

  // A write scheduled on a reset edge is dropped; earlier beats stay in the array.
  always_ff @(posedge clock) begin
    if (we && !reset) mem[waddr] <= wbyte;
  end

  assign bus.memory_data         = mdata_q;
  assign bus.reset_memory_access = (state_q == ST_ACK);
  assign bus.busy                = (state_q != ST_IDLE);
  assign bus.conflict_error      = conflict_q;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: two instances (0 and 3 wait states),
// directed requests with hand-computed memory_data and ACK latency.
module tb_memory_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_responder_if bus0 ();
  memory_responder_if bus3 ();

  memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clock(clk), .reset(rst), .bus(bus0.slave));
  memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3)) dut3 (
    .clock(clk), .reset(rst), .bus(bus3.slave));

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned acks0 = 0, acks3 = 0, reqs0 = 0, reqs3 = 0;
  logic [15:0] q0[$];
  logic [15:0] q3[$];

  localparam logic [3:0] LB = 4'b0001, LH = 4'b0010, SB = 4'b0100, SH = 4'b1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_flags(input int d, input logic [3:0] f, input logic [15:0] a,
                           input logic [15:0] dt);
    if (d == 0) begin
      {bus0.memory_access_store_halfword, bus0.memory_access_store_byte,
       bus0.memory_access_load_halfword,  bus0.memory_access_load_byte} = f;
      bus0.target_address = a;
      bus0.target_data    = dt;
    end else begin
      {bus3.memory_access_store_halfword, bus3.memory_access_store_byte,
       bus3.memory_access_load_halfword,  bus3.memory_access_load_byte} = f;
      bus3.target_address = a;
      bus3.target_data    = dt;
    end
  endtask

  function automatic logic get_ack(input int d);
    return (d == 0) ? bus0.reset_memory_access : bus3.reset_memory_access;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? bus0.busy : bus3.busy;
  endfunction

  // Issue one request, act as the requester (drop flags on the edge sampling ACK),
  // check latency and that the pulse lasts a single cycle.
  task automatic do_req(input int d, input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] dt, input logic [15:0] exp_md,
                        input int exp_lat, input string tag, output logic [7:0] busy_map);
    int lat;
    lat = -1;
    busy_map = '0;
    @(posedge clk); #1;
    if (d == 0) begin q0.push_back(exp_md); reqs0++; end
    else        begin q3.push_back(exp_md); reqs3++; end
    set_flags(d, f, a, dt);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c < 8) busy_map[c] = get_busy(d);
      if (get_ack(d)) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    set_flags(d, 4'b0000, 16'h0000, 16'h0000);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_ack_once"}, 32'(get_ack(d)), 32'd0);
    chk({tag, "_idle"}, 32'(get_busy(d)), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus0.reset_memory_access) begin
      acks0++;
      if (q0.size() == 0) chk("unexpected_ack0", 32'(q0.size()), 32'd1);
      else chk("mdata0", 32'(bus0.memory_data), 32'(q0.pop_front()));
    end
    if (!rst && bus3.reset_memory_access) begin
      acks3++;
      if (q3.size() == 0) chk("unexpected_ack3", 32'(q3.size()), 32'd1);
      else chk("mdata3", 32'(bus3.memory_data), 32'(q3.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bm;
    rst = 1'b1;
    set_flags(0, 4'b0000, 16'h0000, 16'h0000);
    set_flags(3, 4'b0000, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mdata0", 32'(bus0.memory_data), 32'h0000);
    chk("rst_ack0", 32'(bus0.reset_memory_access), 32'd0);
    chk("rst_busy0", 32'(bus0.busy), 32'd0);
    chk("rst_conf0", 32'(bus0.conflict_error), 32'd0);
    chk("rst_busy3", 32'(bus3.busy), 32'd0);

    // Halfword store then load; busy covers cycles 1..3.
    do_req(0, SH, 16'h0010, 16'hBEEF, 16'h0000, 3, "sh_beef", bm);
    chk("sh_busy_map", 32'(bm), 32'h0E);
    do_req(0, LH, 16'h0010, 16'h0000, 16'hBEEF, 3, "lh_beef", bm);
    chk("lh_busy_map", 32'(bm), 32'h0E);

    // Byte store into the upper byte, then reads.
    do_req(0, SB, 16'h0011, 16'h0042, 16'hBEEF, 2, "sb_42", bm);
    do_req(0, LH, 16'h0010, 16'h0000, 16'h42EF, 3, "lh_42ef", bm);
    do_req(0, LB, 16'h0010, 16'h0000, 16'h00EF, 2, "lb_ef", bm);

    // Wrap at top of RAM with upper address bits ignored.
    do_req(0, SH, 16'hA2FF, 16'h1234, 16'h00EF, 3, "sh_wrap", bm);
    do_req(0, LB, 16'h0000, 16'h0000, 16'h0012, 2, "lb_00", bm);
    do_req(0, LB, 16'h00FF, 16'h0000, 16'h0034, 2, "lb_ff", bm);

    // Conflicting flags: store_byte wins, sticky error.
    chk("conf_before", 32'(bus0.conflict_error), 32'd0);
    do_req(0, LB | SB, 16'h0020, 16'h0077, 16'h0034, 2, "conflict", bm);
    chk("conf_set", 32'(bus0.conflict_error), 32'd1);
    do_req(0, LB, 16'h0020, 16'h0000, 16'h0077, 2, "lb_77", bm);
    chk("conf_sticky", 32'(bus0.conflict_error), 32'd1);

    // Wait-state instance.
    do_req(3, SB, 16'h0005, 16'h003C, 16'h0000, 5, "w3_sb", bm);
    do_req(3, LB, 16'h0005, 16'h0000, 16'h003C, 5, "w3_lb", bm);
    do_req(3, SH, 16'h0006, 16'hA55A, 16'h003C, 6, "w3_sh", bm);
    do_req(3, LH, 16'h0006, 16'h0000, 16'hA55A, 6, "w3_lh", bm);
    chk("w3_ack_count", acks3, reqs3);

    // Reset during the high beat of a halfword store.
    do_req(0, SB, 16'h0031, 16'h0099, 16'h0077, 2, "sb_31", bm);
    @(posedge clk); #1;
    set_flags(0, SH, 16'h0030, 16'hAB55);
    @(negedge clk);
    chk("abort_c0_ack", 32'(bus0.reset_memory_access), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_c1_busy", 32'(bus0.busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_c2_busy", 32'(bus0.busy), 32'd1);
    chk("abort_c2_ack", 32'(bus0.reset_memory_access), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_flags(0, 4'b0000, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("abort_mdata", 32'(bus0.memory_data), 32'h0000);
    chk("abort_busy", 32'(bus0.busy), 32'd0);
    chk("abort_ack", 32'(bus0.reset_memory_access), 32'd0);
    chk("abort_conf", 32'(bus0.conflict_error), 32'd0);
    @(negedge clk);
    chk("abort_no_late_ack", 32'(bus0.reset_memory_access), 32'd0);
    do_req(0, LB, 16'h0030, 16'h0000, 16'h0055, 2, "lb_30", bm);
    do_req(0, LB, 16'h0031, 16'h0000, 16'h0099, 2, "lb_31", bm);

    repeat (4) @(negedge clk);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q3_empty", 32'(q3.size()), 32'd0);
    chk("ack0_count", acks0, reqs0);
    chk("ack3_count", acks3, reqs3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
